// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned SEG_W  = 8;

  // Bit positions inside the {a,b,c,d,e,f,g,dp} segment word.
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  // Active-high {a,b,c,d,e,f,g} pattern for a hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high a..g segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex2seg(nib_i);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadow registers, prescaled digit scan with a
// blank guard cycle per slot, leading-zero suppression and selectable output polarity.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic [SEG_W-1:0]      seg_out,
  output logic [DIGITS-1:0]     an_out
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0]   CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxMax = IdxW'(DIGITS - 1);
  // XOR masks: all ones invert to active-low, all zeros leave active-high.
  localparam logic [SEG_W-1:0]  SegOff = {SEG_W{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AnOff  = {DIGITS{ACTIVE_LOW}};

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [DIGITS-1:0]   zero_from;
  logic [DIGITS-1:0]   dig_an;
  logic [3:0]          dig_nib;
  logic                dig_dp;
  logic                dig_blank;
  logic                dig_zero;
  logic                suppress;
  logic [6:0]          dec_seg;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      run          = run & (val_q[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

  always_comb begin
    dig_an    = '0;
    dig_nib   = '0;
    dig_dp    = 1'b0;
    dig_blank = 1'b0;
    dig_zero  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        dig_an[i] = 1'b1;
        dig_nib   = val_q[4*i +: 4];
        dig_dp    = dp_q[i];
        dig_blank = blank_q[i];
        dig_zero  = zero_from[i];
      end
    end
    suppress = lz_en && (idx_q != '0) && dig_zero;
  end

  seg_hex_decode u_dec (
    .nib_i (dig_nib),
    .seg_o (dec_seg)
  );

  // Built active-high; cnt_q == 0 is the dark anti-ghost cycle.
  always_comb begin
    seg_d = '0;
    an_d  = '0;
    if (cnt_q != '0) begin
      an_d = dig_an;
      if (!dig_blank) begin
        seg_d[SEG_A:SEG_G] = suppress ? 7'b0 : dec_seg;
        seg_d[SEG_DP]      = dig_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '1;
      seg_q   <= SegOff;
      an_q    <= AnOff;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (load) begin
        val_q   <= value;
        dp_q    <= dp;
        blank_q <= blank;
      end
      seg_q <= seg_d ^ SegOff;
      an_q  <= an_d ^ AnOff;
    end
  end

  assign seg_out = seg_q;
  assign an_out  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor compares both an
// active-low and an active-high instance driven by the same inputs.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [7:0]  seg_lo, seg_hi;
  logic [3:0]  an_lo, an_hi;

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] an;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .value   (value),
    .dp      (dp),
    .blank   (blank),
    .lz_en   (lz_en),
    .seg_out (seg_lo),
    .an_out  (an_lo)
  );

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_ah (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .value   (value),
    .dp      (dp),
    .blank   (blank),
    .lz_en   (lz_en),
    .seg_out (seg_hi),
    .an_out  (an_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {seg,an}=%h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output after edge k shows the state of tick k-1: guard on slot start, else digit.
  function automatic int slot_digit(input int k);
    if ((k - 1) % 4 == 0) return -1;
    return ((k - 1) / 4) % 4;
  endfunction

  // tbl holds expected active-low seg codes, digit d at tbl[8d +: 8].
  task automatic push_range(input int k0, input int k1, input logic [31:0] tbl,
                            input string name);
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      int d;
      d      = slot_digit(k);
      e.cyc  = k;
      e.name = name;
      if (d < 0) begin
        e.seg = 8'hFF;
        e.an  = 4'hF;
      end else begin
        e.seg = tbl[8*d +: 8];
        e.an  = ~(4'b0001 << d);
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s: cycle %0d expectation not sampled (now %0d)", e.name, e.cyc, cyc);
        end else begin
          chk({e.name, "_lo"}, {seg_lo, an_lo}, {e.seg, e.an});
          chk({e.name, "_hi"}, {seg_hi, an_hi}, ~{e.seg, e.an});
        end
      end
    end
  end

  initial begin
    exp_t e;
    n_chk  = 0;
    n_fail = 0;
    load   = 1'b0;
    value  = 16'h0000;
    dp     = 4'h0;
    blank  = 4'h0;
    lz_en  = 1'b0;
    rst    = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_lo", {seg_lo, an_lo}, 12'hFFF);
    chk("reset_hi", {seg_hi, an_hi}, 12'h000);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Shadow blank is all ones after reset: anodes scan, segments dark.
    push_range(1, 8, 32'hFFFF_FFFF, "boot");

    wait_cyc(7);
    value = 16'h321A;
    load  = 1'b1;
    push_range(9, 29, {8'h0D, 8'h25, 8'h9F, 8'h11}, "scan");
    wait_cyc(8);
    load  = 1'b0;

    // Mid-slot load lands while digit 3 is lit.
    wait_cyc(28);
    value = 16'h0001;
    dp    = 4'b0001;
    blank = 4'b0100;
    load  = 1'b1;
    push_range(30, 47, {8'h03, 8'hFF, 8'h03, 8'h9E}, "dp_blank");
    wait_cyc(29);
    load  = 1'b0;

    // lz_en is live: cycle 48 shows the old digit 3 (zero) already suppressed.
    wait_cyc(47);
    value = 16'h0050;
    dp    = 4'b0000;
    blank = 4'b0000;
    lz_en = 1'b1;
    load  = 1'b1;
    e.cyc  = 48;
    e.seg  = 8'hFF;
    e.an   = 4'h7;
    e.name = "lz_live";
    q.push_back(e);
    push_range(49, 64, {8'hFF, 8'hFF, 8'h49, 8'h03}, "lz_0050");
    wait_cyc(48);
    load  = 1'b0;

    wait_cyc(63);
    value = 16'h0000;
    load  = 1'b1;
    push_range(65, 80, {8'hFF, 8'hFF, 8'hFF, 8'h03}, "lz_0000");
    wait_cyc(64);
    load  = 1'b0;

    wait_cyc(80);
    lz_en = 1'b0;
    push_range(81, 82, {8'h03, 8'h03, 8'h03, 8'h03}, "midload_old");
    push_range(83, 95, {8'h03, 8'h03, 8'h03, 8'h01}, "midload_new");
    wait_cyc(81);
    value = 16'h0008;
    load  = 1'b1;
    wait_cyc(82);
    load  = 1'b0;

    // Asynchronous reset in the middle of a lit slot.
    wait_cyc(96);
    rst = 1'b1;
    #1;
    chk("midrst_lo", {seg_lo, an_lo}, 12'hFFF);
    chk("midrst_hi", {seg_hi, an_hi}, 12'h000);
    @(posedge clk);
    #2 rst = 1'b0;
    push_range(1, 8, 32'hFFFF_FFFF, "post_rst");
    wait_cyc(10);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
